pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Y86 pipeline hazard/stall controller with memory-wait timeout and halt FSM.
// Optional stall/bubble performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int RW    = 4,
  parameter int NSRC  = 2,
  parameter int TMO   = 15,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           D_icode,
  input  logic [3:0]           E_icode,
  input  logic [3:0]           M_icode,
  input  logic [NSRC*RW-1:0]   d_src,
  input  logic [RW-1:0]        E_dstM,
  input  logic                 e_cond,
  input  logic                 m_hlt,
  input  logic                 m_in_inst,
  input  logic                 m_in_mem,
  input  logic                 w_hlt,
  input  logic                 w_in_inst,
  input  logic                 w_in_mem,
  input  logic                 mem_ready,
  output logic                 F_stall,
  output logic                 D_stall,
  output logic                 E_stall,
  output logic                 M_stall,
  output logic                 W_stall,
  output logic                 D_bubble,
  output logic                 E_bubble,
  output logic                 M_bubble,
  output logic                 W_bubble,
  output logic                 halted,
  output logic                 mem_tmo
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bub_cnt
`endif
);

  localparam logic [RW-1:0] RNONE = {RW{1'b1}};
  localparam logic [7:0]    TMO8  = 8'(TMO);

  typedef enum logic [1:0] {RUN, MWAIT, HALT} state_e;

  state_e     state_q;
  logic [7:0] wcnt_q;
  logic       halted_q, tmo_q;

  logic [NSRC-1:0] src_hit;
  logic m_memop, e_load, load_use, mispred, ret_any, m_exc, w_exc, mem_wait;
  logic [7:0] wcnt_inc;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign src_hit[k] = (d_src[k*RW +: RW] == E_dstM);
  end

  assign m_memop  = M_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign e_load   = E_icode inside {4'h5, 4'hB};
  assign load_use = e_load && (E_dstM != RNONE) && (|src_hit);
  assign mispred  = (E_icode == 4'h7) && !e_cond;
  assign ret_any  = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  assign m_exc    = m_hlt | m_in_inst | m_in_mem;
  assign w_exc    = w_hlt | w_in_inst | w_in_mem;
  // Once ready arrives in MWAIT the access is complete, so that cycle runs normally.
  assign mem_wait = !mem_ready && ((state_q == MWAIT) || m_memop);
  assign wcnt_inc = wcnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wcnt_q   <= '0;
      halted_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (w_exc) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (m_memop && !mem_ready) begin
            state_q <= MWAIT;
            wcnt_q  <= '0;
          end
        end
        MWAIT: begin
          if (w_exc) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (mem_ready) begin
            state_q <= RUN;
          end else begin
            wcnt_q <= wcnt_inc;
            if (wcnt_inc == TMO8) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
              tmo_q    <= 1'b1;
            end
          end
        end
        HALT:    ;
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    if (!rst_n) begin
      F_stall = 1'b0;
    end else if (state_q == HALT) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_stall = 1'b1;
    end else begin
      if (w_exc) begin
        W_stall = 1'b1;
      end else if (mem_wait) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_stall  = 1'b1;
        M_stall  = 1'b1;
        W_bubble = 1'b1;
      end else if (load_use) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
      end else if (mispred) begin
        // A ret already in M is on the correct path and still needs fetch held.
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        F_stall  = (M_icode == 4'h9);
      end else if (ret_any) begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
      end
      if (m_exc || w_exc) begin
        M_bubble = 1'b1;
        M_stall  = 1'b0;
      end
    end
  end

  assign halted  = halted_q;
  assign mem_tmo = tmo_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, bub_cnt_q;
  logic             any_bub;

  assign any_bub = D_bubble | E_bubble | M_bubble | W_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      bub_cnt_q   <= '0;
    end else if (state_q != HALT) begin
      if (F_stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (any_bub && !(&bub_cnt_q))   bub_cnt_q   <= bub_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign bub_cnt   = bub_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expected controls,
// a negedge monitor pops and compares; async reset is checked between clock edges.
module tb_pipe_ctrl;
  localparam int RW = 4, NSRC = 2, TMO = 4, CNT_W = 16;

  localparam logic [8:0] FS = 9'h100, DS = 9'h080, ES = 9'h040, MS = 9'h020, WS = 9'h010;
  localparam logic [8:0] DB = 9'h008, EB = 9'h004, MB = 9'h002, WB = 9'h001;
  localparam logic [8:0] ALLS = FS | DS | ES | MS | WS;
  localparam logic [8:0] WAIT = FS | DS | ES | MS | WB;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic rst_n;
  logic [3:0] D_icode, E_icode, M_icode;
  logic [NSRC*RW-1:0] d_src;
  logic [RW-1:0] E_dstM;
  logic e_cond, m_hlt, m_in_inst, m_in_mem, w_hlt, w_in_inst, w_in_mem, mem_ready;
  logic F_stall, D_stall, E_stall, M_stall, W_stall;
  logic D_bubble, E_bubble, M_bubble, W_bubble, halted, mem_tmo;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt, bub_cnt;
`endif
  logic [8:0] ctrl;
  assign ctrl = {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble};

  pipe_ctrl #(.RW(RW), .NSRC(NSRC), .TMO(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_src(d_src), .E_dstM(E_dstM), .e_cond(e_cond),
    .m_hlt(m_hlt), .m_in_inst(m_in_inst), .m_in_mem(m_in_mem),
    .w_hlt(w_hlt), .w_in_inst(w_in_inst), .w_in_mem(w_in_mem),
    .mem_ready(mem_ready),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
    .halted(halted), .mem_tmo(mem_tmo)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .bub_cnt(bub_cnt)
`endif
  );

  typedef struct {
    logic [8:0] ctrl;
    logic       hlt;
    logic       tmo;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int ncmp = 0;
  int nbad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, {21'b0, ctrl, halted, mem_tmo}, {21'b0, e.ctrl, e.hlt, e.tmo});
      end
    end
  end

  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_src = '1; E_dstM = '1; e_cond = 1'b1;
    m_hlt = 0; m_in_inst = 0; m_in_mem = 0;
    w_hlt = 0; w_in_inst = 0; w_in_mem = 0;
    mem_ready = 1'b1;
  endtask

  task automatic cyc(input logic [8:0] c, input logic h, input logic t, input string nm);
    exp_t e;
    e.ctrl = c; e.hlt = h; e.tmo = t; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Called 1 time unit after a rising edge; pulses reset well before the next edge.
  task automatic arst(input string nm);
    #2 rst_n = 1'b0;
    #1;
    chk({nm, "_ctrl"}, {23'b0, ctrl}, 32'd0);
    chk({nm, "_halted"}, {31'b0, halted}, 32'd0);
    chk({nm, "_tmo"}, {31'b0, mem_tmo}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk({nm, "_scnt"}, 32'(stall_cnt), 32'd0);
    chk({nm, "_bcnt"}, 32'(bub_cnt), 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    cyc(9'h0, 0, 0, "rst0");
    cyc(9'h0, 0, 0, "rst1");
    rst_n = 1'b1;
    cyc(9'h0, 0, 0, "idle");

    E_icode = 4'h5; E_dstM = 4'h3; d_src = 8'h3F;
    cyc(FS | DS | EB, 0, 0, "lu_ch1");
    idle(); E_icode = 4'hB; E_dstM = 4'h3; d_src = 8'hF3;
    cyc(FS | DS | EB, 0, 0, "lu_ch0");
    idle(); E_icode = 4'h5;
    cyc(9'h0, 0, 0, "lu_rnone");
    idle(); E_icode = 4'h2; E_dstM = 4'h3; d_src = 8'h33;
    cyc(9'h0, 0, 0, "not_load");
    idle(); E_icode = 4'h7; e_cond = 1'b0;
    cyc(DB | EB, 0, 0, "mispred");
    idle(); E_icode = 4'h7;
    cyc(9'h0, 0, 0, "jxx_taken");
    idle(); D_icode = 4'h9;
    cyc(FS | DB, 0, 0, "ret_d");
    idle(); E_icode = 4'h7; e_cond = 1'b0; M_icode = 4'h9;
    cyc(FS | DB | EB, 0, 0, "misp_ret_m");
    idle(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_src = 8'hF3;
    cyc(FS | DS | EB, 0, 0, "lu_over_ret");
    idle(); m_hlt = 1'b1;
    cyc(MB, 0, 0, "m_hlt");

    idle(); M_icode = 4'h5; mem_ready = 1'b0;
    repeat (3) cyc(WAIT, 0, 0, "mwait");
    mem_ready = 1'b1;
    cyc(9'h0, 0, 0, "mdone");
    idle(); mem_ready = 1'b0;
    cyc(9'h0, 0, 0, "run_after_mwait");

    idle(); M_icode = 4'h4; mem_ready = 1'b0; m_in_mem = 1'b1;
    cyc(FS | DS | ES | MB | WB, 0, 0, "mwait_mexc");
    idle();
    cyc(9'h0, 0, 0, "mdone2");

    M_icode = 4'h4; mem_ready = 1'b0;
    repeat (4) cyc(WAIT, 0, 0, "pre_tmo");
    mem_ready = 1'b1;
    cyc(9'h0, 0, 0, "ready_at_tmo");
    idle(); mem_ready = 1'b0;
    cyc(9'h0, 0, 0, "run_after_near_tmo");

    idle(); M_icode = 4'h4; mem_ready = 1'b0;
    cyc(WAIT, 0, 0, "mw_a");
    cyc(WAIT, 0, 0, "mw_b");
    arst("rst_mwait");
    idle(); mem_ready = 1'b0;
    cyc(9'h0, 0, 0, "run_after_rst");

    idle(); w_in_mem = 1'b1;
    cyc(WS | MB, 0, 0, "w_exc");
    idle();
    cyc(ALLS, 1, 0, "halt");
    E_icode = 4'h5; E_dstM = 4'h3; d_src = 8'hF3;
    cyc(ALLS, 1, 0, "halt_hold");
    arst("rst_halt");
    idle();
    cyc(9'h0, 0, 0, "run_post_halt");

    M_icode = 4'h4; mem_ready = 1'b0;
    repeat (5) cyc(WAIT, 0, 0, "tmo_wait");
    cyc(ALLS, 1, 1, "tmo_halt");
    idle();
    cyc(ALLS, 1, 1, "tmo_hold");
    arst("rst_tmo");
    idle();
    cyc(9'h0, 0, 0, "final");

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      ncmp++;
      nbad++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
